shift_deserializer: RTL and testbench

//  Receive end of the serial shift path: collects a bit stream (as shifted out by univ_shifter)

---
 rtl/shift_pkg.sv | 14 +
 rtl/deser_out_reg.sv | 41 ++++
 rtl/shift_deserializer.sv | 110 +++++++++++
 tb/tb_shift_deserializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the serial shift path: deserializer FSM states and bit-order codes.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_DONE
    } deser_state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/deser_out_reg.sv
// Valid/ready output holding register for assembled words.
// Optional SHIFT_PARITY_EN adds a parity_err flag that travels with the word.
module deser_out_reg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] din,
`ifdef SHIFT_PARITY_EN
    input  logic         perr_in,
    output logic         parity_err,
`endif
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid
);

    // Load takes priority over drain so a simultaneous drain+load keeps out_valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef SHIFT_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (load) begin
            out_data  <= din;
            out_valid <= 1'b1;
`ifdef SHIFT_PARITY_EN
            parity_err <= perr_in;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef SHIFT_PARITY_EN
            parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects N bits (MSB- or LSB-first) into a word and
// presents it on a valid/ready port. Optional macro SHIFT_PARITY_EN adds one
// even-parity bit per word and the parity_err output.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic         ser_ready,
    input  logic         dir,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef SHIFT_PARITY_EN
    output logic         parity_err,
`endif
    output logic [15:0]  word_cnt
);

    localparam int CNT_W = $clog2(N + 1);

    deser_state_e     state, state_n;
    logic [N-1:0]     sreg, shifted;
    logic [CNT_W-1:0] cnt;
    logic             dir_q, eff_dir;
    logic             free, take, start, load;
`ifdef SHIFT_PARITY_EN
    logic             par_q;
`endif

    // Handshake decode, bit-order select and next-state logic.
    // A bit offered while DONE can drain is taken as the first bit of the next word.
    always_comb begin
        free      = !out_valid || out_ready;
        ser_ready = !((state == S_DONE) && !free);
        take      = ser_valid && ser_ready;
        start     = take && ((state == S_IDLE) || (state == S_DONE));
        eff_dir   = start ? dir : dir_q;
        shifted   = (eff_dir == DIR_MSB_FIRST) ? {sreg[N-2:0], ser_in}
                                               : {ser_in, sreg[N-1:1]};
        load      = (state == S_DONE) && free;
        state_n   = state;
        case (state)
            S_IDLE:   if (take) state_n = S_SHIFT;
            S_SHIFT:  if (take && (cnt == CNT_W'(N - 1))) begin
`ifdef SHIFT_PARITY_EN
                          state_n = S_PARITY;
`else
                          state_n = S_DONE;
`endif
                      end
            S_PARITY: if (take) state_n = S_DONE;
            S_DONE:   if (free) state_n = take ? S_SHIFT : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Shift register, bit counter and word-order latch; dir is frozen at the first bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg  <= '0;
            cnt   <= '0;
            dir_q <= DIR_MSB_FIRST;
`ifdef SHIFT_PARITY_EN
            par_q <= 1'b0;
`endif
        end else if (take) begin
            if (state == S_PARITY) begin
`ifdef SHIFT_PARITY_EN
                par_q <= ser_in;
`endif
            end else begin
                sreg <= shifted;
                cnt  <= start ? CNT_W'(1) : cnt + CNT_W'(1);
                if (start) dir_q <= dir;
            end
        end
    end

    // Delivered-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       word_cnt <= '0;
        else if (out_valid && out_ready)  word_cnt <= word_cnt + 16'd1;
    end

    deser_out_reg #(.N(N)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .din       (sreg),
`ifdef SHIFT_PARITY_EN
        .perr_in   (^{sreg, par_q}),
        .parity_err(parity_err),
`endif
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed + table-driven + scoreboarded random bench for shift_deserializer (N=16).
module tb_shift_deserializer;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ser_in = 1'b0, ser_valid = 1'b0, dir = 1'b0, out_ready = 1'b1;
    logic        ser_ready, out_valid;
    logic [15:0] out_data, word_cnt;
`ifdef SHIFT_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_deserializer #(.N(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .dir       (dir),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFT_PARITY_EN
        .parity_err(parity_err),
`endif
        .word_cnt  (word_cnt)
    );

    typedef struct {
        logic [15:0] stream;   // bits in send order, bit 15 first
        logic        d;
        logic        tog;      // toggle dir after the first bit
        logic [15:0] exp;
    } vec_t;

    vec_t vt[8];
    logic [15:0] sb[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Offer one bit until the DUT takes it; acceptance is judged just before the edge.
    task automatic send_bit(input logic b, input logic d);
        logic rdy;
        int   n;
        ser_valid = 1'b1;
        ser_in    = b;
        dir       = d;
        n         = 0;
        do begin
            @(negedge clk);
            rdy = ser_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 500);
        if (!rdy) fail_timeout("ser_ready_wait");
    endtask

    task automatic send_stream(input logic [15:0] s, input logic d, input logic tog, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                ser_valid = 1'b0;
                ser_in    = 1'($urandom);
                dir       = 1'($urandom);
                repeat ($urandom_range(1, 2)) step();
            end
            send_bit(s[15-i], (tog && i > 0) ? ~d : d);
        end
    endtask

    task automatic send_word(input logic [15:0] s, input logic d, input logic tog, input bit gaps);
        send_stream(s, d, tog, gaps);
`ifdef SHIFT_PARITY_EN
        send_bit(^s, d);
`endif
        ser_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) fail_timeout(name);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ser_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        vt[0] = '{16'h00FF, DIR_MSB_FIRST, 1'b0, 16'h00FF};
        vt[1] = '{16'h0100, DIR_LSB_FIRST, 1'b1, 16'h0080};
        vt[2] = '{16'h0001, DIR_LSB_FIRST, 1'b0, 16'h8000};
        vt[3] = '{16'h1234, DIR_LSB_FIRST, 1'b0, 16'h2C48};
        vt[4] = '{16'hABCD, DIR_MSB_FIRST, 1'b1, 16'hABCD};
        vt[5] = '{16'hC000, DIR_LSB_FIRST, 1'b1, 16'h0003};
        vt[6] = '{16'hFFFF, DIR_LSB_FIRST, 1'b0, 16'hFFFF};
        vt[7] = '{16'h0000, DIR_MSB_FIRST, 1'b0, 16'h0000};

        // Reset held with bits offered.
        reset     = 1'b0;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_word_cnt", word_cnt, 16'd0);
        chk("rst_ser_ready", 16'(ser_ready), 16'd1);
        chk("rst_out_data", out_data, 16'd0);
        ser_valid = 1'b0;
        reset     = 1'b1;
        step();

        // Table: one word each, out_ready high, check one-cycle latency and data.
        for (int v = 0; v < 8; v++) begin
            send_word(vt[v].stream, vt[v].d, vt[v].tog, 1'b0);
            chk("tbl_early_valid", 16'(out_valid), 16'd0);
            step();
            chk("tbl_valid", 16'(out_valid), 16'd1);
            chk("tbl_data", out_data, vt[v].exp);
        end
        step();
        chk("tbl_word_cnt", word_cnt, 16'd8);

        // Back-pressure: two words stall, third word's first bit waits.
        do_reset();
        out_ready = 1'b0;
        send_word(16'h1234, DIR_MSB_FIRST, 1'b0, 1'b0);
        send_word(16'hABCD, DIR_MSB_FIRST, 1'b0, 1'b0);
        fork
            send_word(16'h8001, DIR_MSB_FIRST, 1'b0, 1'b0);
            begin
                step();
                step();
                chk("bp_ser_ready", 16'(ser_ready), 16'd0);
                chk("bp_valid", 16'(out_valid), 16'd1);
                chk("bp_hold", out_data, 16'h1234);
                chk("bp_cnt0", word_cnt, 16'd0);
                out_ready = 1'b1;
                step();
                chk("bp_second", out_data, 16'hABCD);
                chk("bp_valid2", 16'(out_valid), 16'd1);
                chk("bp_cnt1", word_cnt, 16'd1);
                step();
                chk("bp_drained", 16'(out_valid), 16'd0);
                chk("bp_cnt2", word_cnt, 16'd2);
            end
        join
        wait_out("bp_third_wait");
        chk("bp_third", out_data, 16'h8001);
        step();
        chk("bp_cnt3", word_cnt, 16'd3);

        // Reset mid-word discards the partial word.
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(1'b1, DIR_MSB_FIRST);
        reset     = 1'b0;
        ser_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_cnt", word_cnt, 16'd0);
        send_word(16'h5A5A, DIR_MSB_FIRST, 1'b0, 1'b0);
        wait_out("mid_rst_wait");
        chk("mid_rst_data", out_data, 16'h5A5A);
        step();
        step();
        chk("mid_rst_cnt1", word_cnt, 16'd1);
        chk("mid_rst_no_extra", 16'(out_valid), 16'd0);

`ifdef SHIFT_PARITY_EN
        // Parity: good and bad parity bit, word delivered either way.
        do_reset();
        send_stream(16'h0001, DIR_MSB_FIRST, 1'b0, 1'b0);
        send_bit(1'b1, DIR_MSB_FIRST);
        ser_valid = 1'b0;
        wait_out("par_ok_wait");
        chk("par_ok_data", out_data, 16'h0001);
        chk("par_ok_err", 16'(parity_err), 16'd0);
        step();
        send_stream(16'h0001, DIR_MSB_FIRST, 1'b0, 1'b0);
        send_bit(1'b0, DIR_MSB_FIRST);
        ser_valid = 1'b0;
        wait_out("par_bad_wait");
        chk("par_bad_data", out_data, 16'h0001);
        chk("par_bad_err", 16'(parity_err), 16'd1);
        step();
`endif

        // Random words, both orders, with input and output gaps, checked in send order.
        do_reset();
        fork
            begin
                for (int w = 0; w < 100; w++) begin
                    logic [15:0] word;
                    logic        d;
                    word = 16'($urandom);
                    d    = 1'($urandom);
                    sb.push_back(word);
                    send_word(d ? rev16(word) : word, d, 1'b0, 1'b1);
                end
            end
            begin
                int got, cyc;
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 40000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            fail_timeout("rand_unexpected_word");
                        end else begin
                            chk("rand_word", out_data, sb.pop_front());
                        end
                        got++;
                    end
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                if (got < 100) fail_timeout("rand_receive");
            end
        join
        out_ready = 1'b1;
        step();
        chk("rand_word_cnt", word_cnt, 16'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
